// File: rtl/complex_vec_chunk_feeder.sv
// complex_vec_chunk_feeder
// Holds two NOE-element complex vectors (first and second operand of
// result = second +/- first*constant) and, on start, streams them to the
// engine as NI-lane beats with a valid/ready handshake. Lanes past the end
// of the vectors in the final beat are driven as zero so every beat is a
// full NI-lane word. Lane 0 sits in the MSBs of each row.
module complex_vec_chunk_feeder #(
  parameter int NOE           = 16,
  parameter int NI            = 8,
  parameter int element_width = 64,
  parameter int AW            = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic                        wr_sel,
  input  logic [AW-1:0]               wr_addr,
  input  logic [element_width-1:0]    wr_data,
  input  logic                        start,
  input  logic                        op_in,
  input  logic [element_width-1:0]    constant_in,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [element_width*NI-1:0] first_row_out,
  output logic [element_width*NI-1:0] second_row_out,
  output logic [element_width-1:0]    constant_out,
  output logic                        op_out,
  output logic                        last,
  output logic [AW-1:0]               beat_idx,
  output logic                        busy,
  output logic                        done
);

  localparam int NBEATS = (NOE + NI - 1) / NI;
  localparam int IW     = (NOE > 1) ? $clog2(NOE) : 1;
  localparam int ROW_W  = element_width * NI;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state;

  // Element storage, packed so a whole vector can be handed to the chunk builder
  logic [NOE-1:0][element_width-1:0] first_mem;
  logic [NOE-1:0][element_width-1:0] second_mem;

  logic             wr_accept;
  int               load_beat;
  logic [ROW_W-1:0] next_first;
  logic [ROW_W-1:0] next_second;

  // Gather the NI elements of one beat; element beat*NI+j lands in lane j,
  // and lanes beyond the vector length stay zero.
  function automatic logic [ROW_W-1:0] build_chunk(
    input logic [NOE-1:0][element_width-1:0] mem,
    input int                                beat
  );
    logic [ROW_W-1:0] chunk;
    int               k;
    chunk = '0;
    for (int j = 0; j < NI; j++) begin
      k = beat * NI + j;
      if (k < NOE) begin
        chunk[element_width*(NI-j)-1 -: element_width] = mem[IW'(k)];
      end
    end
    return chunk;
  endfunction

  // A write lands only while idle, never on the start cycle, and only in range
  assign wr_accept = (state == IDLE) && wr_en && !start && (int'(wr_addr) < NOE);

  // Element write port; storage deliberately survives reset
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      if (wr_sel) begin
        second_mem[wr_addr[IW-1:0]] <= wr_data;
      end else begin
        first_mem[wr_addr[IW-1:0]] <= wr_data;
      end
    end
  end

  // Select which beat gets loaded next: beat 0 from idle, otherwise the successor
  always_comb begin
    load_beat = 0;
    if (state == STREAM) begin
      load_beat = int'(beat_idx) + 1;
    end
    next_first  = build_chunk(first_mem, load_beat);
    next_second = build_chunk(second_mem, load_beat);
  end

  // Stream controller with registered beat outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      out_valid      <= 1'b0;
      last           <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      op_out         <= 1'b0;
      beat_idx       <= '0;
      first_row_out  <= '0;
      second_row_out <= '0;
      constant_out   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_out         <= op_in;
            constant_out   <= constant_in;
            first_row_out  <= next_first;
            second_row_out <= next_second;
            beat_idx       <= '0;
            last           <= (load_beat == NBEATS - 1);
            out_valid      <= 1'b1;
            busy           <= 1'b1;
            state          <= STREAM;
          end
        end
        STREAM: begin
          if (out_valid && out_ready) begin
            if (last) begin
              out_valid <= 1'b0;
              last      <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              first_row_out  <= next_first;
              second_row_out <= next_second;
              beat_idx       <= AW'(load_beat);
              last           <= (load_beat == NBEATS - 1);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_complex_vec_chunk_feeder.sv
// Bench for complex_vec_chunk_feeder: two instances (16 and 12 elements,
// both two beats of 8 lanes) share one stimulus stream and are checked
// against an array-based model of the stored vectors.
module tb_complex_vec_chunk_feeder;

  localparam int NI = 8;
  localparam int NB = 2;

  logic        clk = 1'b0;
  logic        reset, wr_en, wr_sel, start, op_in, out_ready;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data, constant_in;

  logic        a_valid, a_op, a_last, a_busy, a_done;
  logic [511:0] a_first, a_second;
  logic [63:0] a_const;
  logic [4:0]  a_bidx;
  logic        b_valid, b_op, b_last, b_busy, b_done;
  logic [511:0] b_first, b_second;
  logic [63:0] b_const;
  logic [4:0]  b_bidx;

  complex_vec_chunk_feeder #(.NOE(16), .NI(8), .element_width(64), .AW(5)) dut_a (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .op_in(op_in), .constant_in(constant_in),
    .out_ready(out_ready), .out_valid(a_valid), .first_row_out(a_first),
    .second_row_out(a_second), .constant_out(a_const), .op_out(a_op), .last(a_last),
    .beat_idx(a_bidx), .busy(a_busy), .done(a_done));

  complex_vec_chunk_feeder #(.NOE(12), .NI(8), .element_width(64), .AW(5)) dut_b (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .op_in(op_in), .constant_in(constant_in),
    .out_ready(out_ready), .out_valid(b_valid), .first_row_out(b_first),
    .second_row_out(b_second), .constant_out(b_const), .op_out(b_op), .last(b_last),
    .beat_idx(b_bidx), .busy(b_busy), .done(b_done));

  always #5 clk = ~clk;

  // Reference contents of the two vectors (16 entries; the 12-element
  // instance simply never exposes entries 12..15)
  logic [63:0] m1 [16];
  logic [63:0] m2 [16];
  logic        exp_op;
  logic [63:0] exp_const;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected row: lanes appended in order, so lane 0 ends up in the MSBs
  function automatic logic [511:0] exp_row(input bit sec, input int noe, input int b);
    logic [511:0] r;
    logic [63:0]  e;
    int           k;
    r = '0;
    for (int j = 0; j < NI; j++) begin
      k = b * NI + j;
      e = 64'h0;
      if (k < noe) e = sec ? m2[k] : m1[k];
      r = (r << 64) | 512'(e);
    end
    return r;
  endfunction

  task automatic check_ctrl(input string tag, input bit v, input bit bsy, input bit dn, input bit lst);
    chk({tag, ".a_valid"}, 512'(a_valid), 512'(v));
    chk({tag, ".a_busy"},  512'(a_busy),  512'(bsy));
    chk({tag, ".a_done"},  512'(a_done),  512'(dn));
    chk({tag, ".a_last"},  512'(a_last),  512'(lst));
    chk({tag, ".a_op"},    512'(a_op),    512'(exp_op));
    chk({tag, ".a_const"}, 512'(a_const), 512'(exp_const));
    chk({tag, ".b_valid"}, 512'(b_valid), 512'(v));
    chk({tag, ".b_busy"},  512'(b_busy),  512'(bsy));
    chk({tag, ".b_done"},  512'(b_done),  512'(dn));
    chk({tag, ".b_last"},  512'(b_last),  512'(lst));
    chk({tag, ".b_op"},    512'(b_op),    512'(exp_op));
    chk({tag, ".b_const"}, 512'(b_const), 512'(exp_const));
  endtask

  task automatic check_beat(input string tag, input int b);
    check_ctrl(tag, 1'b1, 1'b1, 1'b0, (b == NB - 1));
    chk({tag, ".a_bidx"},   512'(a_bidx), 512'(b));
    chk({tag, ".b_bidx"},   512'(b_bidx), 512'(b));
    chk({tag, ".a_first"},  a_first,  exp_row(1'b0, 16, b));
    chk({tag, ".a_second"}, a_second, exp_row(1'b1, 16, b));
    chk({tag, ".b_first"},  b_first,  exp_row(1'b0, 12, b));
    chk({tag, ".b_second"}, b_second, exp_row(1'b1, 12, b));
  endtask

  task automatic check_cleared(input string tag);
    check_ctrl(tag, 1'b0, 1'b0, 1'b0, 1'b0);
    chk({tag, ".a_bidx"},   512'(a_bidx), 512'(0));
    chk({tag, ".b_bidx"},   512'(b_bidx), 512'(0));
    chk({tag, ".a_first"},  a_first,  512'(0));
    chk({tag, ".a_second"}, a_second, 512'(0));
    chk({tag, ".b_first"},  b_first,  512'(0));
    chk({tag, ".b_second"}, b_second, 512'(0));
  endtask

  // Idle-time element write; model follows only in-range addresses
  task automatic wr(input bit sel, input int addr, input logic [63:0] data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = 5'(addr);
    wr_data = data;
    tick();
    wr_en = 1'b0;
    if (addr < 16) begin
      if (sel) m2[addr] = data;
      else     m1[addr] = data;
    end
  endtask

  // One full stream; noise drives writes/start/op/constant that must be ignored
  task automatic run_stream(input logic op, input logic [63:0] cst, input int hold0,
                            input int ready_pct, input bit noise);
    int  cycles;
    int  waited;
    bit  xfer;
    cycles = 0;
    check_ctrl("pre", 1'b0, 1'b0, 1'b0, 1'b0);
    start       = 1'b1;
    op_in       = op;
    constant_in = cst;
    if (noise) begin
      wr_en   = 1'b1;
      wr_sel  = 1'($urandom_range(0, 1));
      wr_addr = 5'($urandom_range(0, 11));
      wr_data = {$urandom, $urandom};
    end
    tick();
    start     = 1'b0;
    wr_en     = 1'b0;
    exp_op    = op;
    exp_const = cst;
    for (int b = 0; b < NB; b++) begin
      waited = 0;
      xfer   = 1'b0;
      while (!xfer) begin
        check_beat($sformatf("beat%0d", b), b);
        if (b == 0 && waited < hold0) out_ready = 1'b0;
        else out_ready = ($urandom_range(0, 99) < ready_pct);
        if (noise) begin
          wr_en       = 1'($urandom_range(0, 1));
          wr_sel      = 1'($urandom_range(0, 1));
          wr_addr     = 5'($urandom_range(0, 15));
          wr_data     = {$urandom, $urandom};
          start       = 1'($urandom_range(0, 1));
          op_in       = ~op;
          constant_in = {$urandom, $urandom};
        end
        xfer = out_ready;
        waited++;
        cycles++;
        tick();
        if (cycles > 400) begin
          chk("stream_timeout", 512'(1), 512'(0));
          out_ready = 1'b0;
          return;
        end
      end
    end
    out_ready = 1'b0;
    wr_en     = 1'b0;
    check_ctrl("done", 1'b0, 1'b0, 1'b1, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_ctrl("after_done", 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; op_in = 1'b0; constant_in = '0; out_ready = 1'b0;
    exp_op = 1'b0; exp_const = '0;
    tick();
    tick();
    check_cleared("reset");
    reset = 1'b0;

    // Directed contents: first[k] = {k,0}, second[k] = {0,k}
    for (int k = 0; k < 16; k++) begin
      wr(1'b0, k, {32'(k), 32'h0});
      wr(1'b1, k, {32'h0, 32'(k)});
    end
    // Out-of-range addresses must leave storage untouched
    wr(1'b0, 16, 64'hDEAD_BEEF_DEAD_BEEF);
    wr(1'b1, 31, 64'hCAFE_F00D_CAFE_F00D);

    run_stream(1'b1, {$urandom, $urandom}, 0, 100, 1'b0);
    // Backpressure on beat 0, constant/op latch, ignored writes and starts
    run_stream(1'b0, 64'h3F800000_00000000, 3, 100, 1'b1);

    // Random contents, random handshake
    for (int i = 0; i < 24; i++) begin
      wr(1'($urandom_range(0, 1)), $urandom_range(0, 31), {$urandom, $urandom});
    end
    run_stream(1'($urandom_range(0, 1)), {$urandom, $urandom}, 0, 50, 1'b1);

    // Reset during beat 1: no done pulse, data survives for the restart
    start = 1'b1; op_in = 1'b1; constant_in = {$urandom, $urandom};
    tick();
    start = 1'b0; exp_op = 1'b1; exp_const = constant_in;
    out_ready = 1'b1;
    tick();
    check_beat("pre_reset", 1);
    out_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_op = 1'b0;
    exp_const = '0;
    check_cleared("mid_reset");
    tick();
    check_ctrl("post_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    run_stream(1'b1, {$urandom, $urandom}, 0, 70, 1'b0);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) begin
        wr(1'($urandom_range(0, 1)), $urandom_range(0, 20), {$urandom, $urandom});
      end
      run_stream(1'($urandom_range(0, 1)), {$urandom, $urandom}, $urandom_range(0, 4), 60, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
